rvm_mem_responder: RTL

Memory-side responder for the core's single-port memory interface. The control FSM drives the address, write data, chip enable and byte enables; this block accepts each request and performs a word-organised SRAM read or write. It inserts a programmable number of wait states using mem_stall and flags illegal accesses on mem_error. It is used as the instruction/data memory in simulation and as the on-chip RAM in small builds.

---
 rtl/rvm_mem_responder_if.sv | 34 +++
 rtl/rvm_mem_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rvm_mem_responder_if.sv
// Single-port memory bus between the core's memory FSM (master) and a
// memory responder (slave).
interface rvm_mem_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic        mem_w_en;
    logic [3:0]  mem_b_en;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_stall;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_c_en,
        output mem_w_en,
        output mem_b_en,
        input  mem_rdata,
        input  mem_error,
        input  mem_stall
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_c_en,
        input  mem_w_en,
        input  mem_b_en,
        output mem_rdata,
        output mem_error,
        output mem_stall
    );
endinterface

// File: rtl/rvm_mem_responder.sv
// Word-organised SRAM responder with programmable wait states and access error
// reporting. Optional feature macro: RVM_MEM_RANDOM_WAIT_EN (LFSR-varied latency).
module rvm_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned CW          = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    rvm_mem_responder_if.slave   mem
);

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned WW = 30;
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q,  state_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [WW-1:0]   addr_q,   addr_d;
    logic [DW-1:0]   wdata_q,  wdata_d;
    logic            w_en_q,   w_en_d;
    logic [BW-1:0]   b_en_q,   b_en_d;
    logic [DW-1:0]   rdata_q,  rdata_d;
    logic            error_q,  error_d;

    logic [DW-1:0]   ram_q [DEPTH_WORDS];

    logic [WW-1:0]   acc_addr_c;
    logic [DW-1:0]   acc_wdata_c;
    logic            acc_w_en_c;
    logic [BW-1:0]   acc_b_en_c;
    logic [AW-1:0]   acc_idx_c;
    logic            acc_err_c;
    logic            lane_ok_c;
    logic [DW-1:0]   lane_mask_c;
    logic [CW-1:0]   load_c;
    logic            do_access_c;
    logic            stall_c;
    logic [BW-1:0]   ram_we_c;

    // Byte offset is not used; lanes are selected by b_en only.
    logic            unused_addr_lsb_c;
    assign unused_addr_lsb_c = ^mem.mem_addr[1:0];

`ifdef RVM_MEM_RANDOM_WAIT_EN
    logic [7:0]      lfsr_q, lfsr_d;

    // Pre-shift LFSR value, clamped to the configured maximum.
    always_comb begin
        load_c = CW'(WAIT_CYCLES);
        if (lfsr_q[CW-1:0] < CW'(WAIT_CYCLES)) begin
            load_c = lfsr_q[CW-1:0];
        end
    end
`else
    always_comb begin
        load_c = CW'(WAIT_CYCLES);
    end
`endif

    // Access operands: live bus in IDLE (zero-wait access), latched copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_addr_c  = mem.mem_addr[31:2];
            acc_wdata_c = mem.mem_wdata;
            acc_w_en_c  = mem.mem_w_en;
            acc_b_en_c  = mem.mem_b_en;
        end else begin
            acc_addr_c  = addr_q;
            acc_wdata_c = wdata_q;
            acc_w_en_c  = w_en_q;
            acc_b_en_c  = b_en_q;
        end
    end

    // Legality: naturally aligned byte, halfword or full word only.
    always_comb begin
        lane_ok_c = 1'b0;
        case (acc_b_en_c)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: lane_ok_c = 1'b1;
            default:                   lane_ok_c = 1'b0;
        endcase
    end

    always_comb begin
        acc_idx_c   = acc_addr_c[AW-1:0];
        acc_err_c   = (acc_addr_c >= WW'(DEPTH_WORDS)) || !lane_ok_c;
        lane_mask_c = '0;
        for (int i = 0; i < int'(BW); i++) begin
            lane_mask_c[8*i +: 8] = {8{acc_b_en_c[i]}};
        end
    end

    // Next-state, latching and response formation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        w_en_d      = w_en_q;
        b_en_d      = b_en_q;
        rdata_d     = '0;
        error_d     = 1'b0;
        do_access_c = 1'b0;
        stall_c     = 1'b0;
        ram_we_c    = '0;
`ifdef RVM_MEM_RANDOM_WAIT_EN
        lfsr_d      = lfsr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                stall_c = mem.mem_c_en;
                if (mem.mem_c_en) begin
                    addr_d  = acc_addr_c;
                    wdata_d = acc_wdata_c;
                    w_en_d  = acc_w_en_c;
                    b_en_d  = acc_b_en_c;
                    cnt_d   = load_c;
`ifdef RVM_MEM_RANDOM_WAIT_EN
                    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                    if (load_c != '0) begin
                        state_d = ST_WAIT;
                    end else begin
                        do_access_c = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    do_access_c = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A write is never committed while reset is held.
        if (do_access_c && resetn) begin
            error_d = acc_err_c;
            if (!acc_err_c) begin
                if (acc_w_en_c) begin
                    ram_we_c = acc_b_en_c;
                end else begin
                    rdata_d = ram_q[acc_idx_c] & lane_mask_c;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            w_en_q  <= 1'b0;
            b_en_q  <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            w_en_q  <= w_en_d;
            b_en_q  <= b_en_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

`ifdef RVM_MEM_RANDOM_WAIT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BW); i++) begin
            if (ram_we_c[i]) begin
                ram_q[acc_idx_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
            end
        end
    end

    assign mem.mem_rdata = rdata_q;
    assign mem.mem_error = error_q;
    assign mem.mem_stall = stall_c;

endmodule
